// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, ALU control codes and zero-register index
package cpu_pkg;
   localparam int DW = 32;
   localparam int AW = 4;
   localparam logic [AW-1:0] ZERO_REG = '0;
   localparam logic [4:0] ALU_AND = 5'b00000;
   localparam logic [4:0] ALU_OR  = 5'b00001;
   localparam logic [4:0] ALU_XOR = 5'b00010;
   localparam logic [4:0] ALU_SLT = 5'b00100;
   localparam logic [4:0] ALU_SUB = 5'b01000;
   localparam logic [4:0] ALU_ADD = 5'b10000;
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: two combinational read ports with write-back bypass, one synchronous write port
module regfile_2r1w #(
   parameter int NREGS = 16,
   parameter int AW = cpu_pkg::AW,
   parameter int DW = cpu_pkg::DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] ra,
   input  logic [AW-1:0] rb,
   output logic [DW-1:0] rdata_a,
   output logic [DW-1:0] rdata_b,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata
);
   import cpu_pkg::*;
   logic [DW-1:0] regs [NREGS];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (we && waddr != AW'(ZERO_REG)) begin
         regs[waddr] <= wdata;
      end
   end
   always_comb begin
      rdata_a = (ra == AW'(ZERO_REG)) ? '0 : (we && waddr == ra) ? wdata : regs[ra];
      rdata_b = (rb == AW'(ZERO_REG)) ? '0 : (we && waddr == rb) ? wdata : regs[rb];
   end
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand fetch with bypass, immediate select and a handshaked output register
module alu_operand_stage #(
   parameter int NREGS = 16,
   parameter int AW = cpu_pkg::AW,
   parameter int DW = cpu_pkg::DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] in_rs,
   input  logic [AW-1:0] in_rt,
   input  logic [AW-1:0] in_rd,
   input  logic [DW-1:0] in_imm,
   input  logic          in_use_imm,
   input  logic [4:0]    in_ctrl,
   input  logic          flush,
   input  logic          wb_en,
   input  logic [AW-1:0] wb_addr,
   input  logic [DW-1:0] wb_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [4:0]    alu_ctrl,
   output logic [AW-1:0] out_rd
);
   import cpu_pkg::*;
   logic [DW-1:0] rdata_a, rdata_b;
   logic          xfer;
   regfile_2r1w #(.NREGS(NREGS), .AW(AW), .DW(DW)) u_rf (
      .clk(clk), .rst_n(rst_n), .ra(in_rs), .rb(in_rt),
      .rdata_a(rdata_a), .rdata_b(rdata_b),
      .we(wb_en), .waddr(wb_addr), .wdata(wb_data)
   );
   assign in_ready = !out_valid || out_ready;
   assign xfer = in_valid && in_ready;
   // flush only kills the valid bit; stale data outputs are harmless once out_valid is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         alu_a <= '0;
         alu_b <= '0;
         alu_ctrl <= '0;
         out_rd <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         alu_a <= rdata_a;
         alu_b <= in_use_imm ? in_imm : rdata_b;
         alu_ctrl <= in_ctrl;
         out_rd <= in_rd;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed checks of operand fetch, bypass, backpressure, flush and reset
module tb_alu_operand_stage;
   logic        clk = 0, rst_n = 0;
   logic        in_valid = 0, in_ready, in_use_imm = 0, flush = 0, wb_en = 0;
   logic [3:0]  in_rs = 0, in_rt = 0, in_rd = 0, wb_addr = 0, out_rd;
   logic [31:0] in_imm = 0, wb_data = 0, alu_a, alu_b;
   logic [4:0]  in_ctrl = 0, alu_ctrl;
   logic        out_valid, out_ready = 1;
   int total = 0, bad = 0;

   alu_operand_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .in_use_imm(in_use_imm), .in_ctrl(in_ctrl), .flush(flush),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a),
      .alu_b(alu_b), .alu_ctrl(alu_ctrl), .out_rd(out_rd)
   );

   always #5 clk = ~clk;

   task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task tick();
      @(posedge clk);
      #1;
   endtask

   task wb(input logic [3:0] a, input logic [31:0] d);
      wb_en = 1; wb_addr = a; wb_data = d;
      tick();
      wb_en = 0;
   endtask

   task issue(input logic [3:0] rs, input logic [3:0] rt, input logic use_imm,
              input logic [31:0] imm, input logic [4:0] ctrl, input logic [3:0] rd);
      in_valid = 1; in_rs = rs; in_rt = rt; in_use_imm = use_imm;
      in_imm = imm; in_ctrl = ctrl; in_rd = rd;
      tick();
      in_valid = 0; wb_en = 0;
   endtask

   initial begin
      int sent, got, cyc;
      logic [31:0] held;
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_a", alu_a, 0);
      chk("rst_b", alu_b, 0);
      chk("rst_ctrl", alu_ctrl, 0);
      chk("rst_rd", out_rd, 0);
      @(negedge clk); rst_n = 1;
      tick();
      wb(3, 512);
      wb(4, 1024);
      issue(3, 4, 0, 0, 5'b10000, 7);
      chk("t1_valid", out_valid, 1);
      chk("t1_a", alu_a, 512);
      chk("t1_b", alu_b, 1024);
      chk("t1_ctrl", alu_ctrl, 5'b10000);
      chk("t1_rd", out_rd, 7);
      chk("t1_sum", alu_a + alu_b, 1536);
      tick();
      chk("t1_drain_valid", out_valid, 0);
      chk("t1_drain_hold", alu_a, 512);
      issue(3, 0, 1, 32'hFFFFFFF6, 5'b01000, 2);
      chk("t2_a", alu_a, 512);
      chk("t2_b", alu_b, 32'hFFFFFFF6);
      wb_en = 1; wb_addr = 5; wb_data = 150;
      issue(5, 5, 0, 0, 5'b10000, 1);
      chk("t3_byp_a", alu_a, 150);
      chk("t3_byp_b", alu_b, 150);
      issue(4, 5, 0, 0, 5'b10000, 1);
      chk("t3_reg5", alu_b, 150);
      chk("t3_reg4", alu_a, 1024);
      wb_en = 1; wb_addr = 0; wb_data = 1243;
      issue(0, 0, 0, 0, 5'b10000, 1);
      chk("t4_zero_byp", alu_a, 0);
      issue(0, 0, 0, 0, 5'b10000, 1);
      chk("t4_zero_reg", alu_b, 0);
      tick();
      // 10-instruction stream with a 3-cycle downstream stall
      sent = 0; got = 0; cyc = 0; held = 0;
      while (got < 10 && cyc < 60) begin
         in_valid = (sent < 10); in_rs = 0; in_use_imm = 1; in_imm = 100 + sent;
         in_rd = 4'(sent);
         out_ready = !(cyc >= 2 && cyc <= 4);
         @(negedge clk);
         if (cyc == 2) held = alu_b;
         if (!out_ready) begin
            chk("t5_stall_ready", in_ready, 0);
            chk("t5_stall_hold", alu_b, held);
            chk("t5_stall_valid", out_valid, 1);
         end
         if (out_valid && out_ready) begin
            chk("t5_order", alu_b, 100 + got);
            got++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge clk); #1;
         cyc++;
      end
      chk("t5_count", got, 10);
      in_valid = 0; out_ready = 1;
      issue(3, 4, 0, 0, 5'b10000, 1);
      chk("t6_pre_valid", out_valid, 1);
      flush = 1; wb_en = 1; wb_addr = 6; wb_data = 77;
      issue(3, 4, 0, 0, 5'b10000, 1);
      flush = 0;
      chk("t6_flush_valid", out_valid, 0);
      issue(6, 0, 0, 0, 5'b10000, 1);
      chk("t6_wb_in_flush", alu_a, 77);
      out_ready = 0;
      issue(3, 4, 0, 0, 5'b10000, 1);
      tick();
      chk("t6_stall_valid", out_valid, 1);
      #2; rst_n = 0; #1;
      chk("t6_arst_valid", out_valid, 0);
      chk("t6_arst_a", alu_a, 0);
      chk("t6_arst_b", alu_b, 0);
      @(negedge clk); rst_n = 1; out_ready = 1;
      tick();
      issue(3, 4, 0, 0, 5'b10000, 1);
      chk("t6_regs_cleared_a", alu_a, 0);
      chk("t6_regs_cleared_b", alu_b, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
